// File: rtl/ram_fill_checker.sv
// ram_fill_checker: on start, waits out SRAM power-up, writes SEED+i*STEP over a wrapping address window, then
// optionally reads it back (RAM_FILL_CHECKER_VERIFY_EN). done after STARTUP_CYC+2*COUNT+RD_LAT+1 cycles; start ignored while busy.
module ram_fill_checker #(
   parameter int AW          = 8,
   parameter int DW          = 8,
   parameter int BASE        = 0,
   parameter int COUNT       = 10,
   parameter int SEED        = 'hA0,
   parameter int STEP        = 1,
   parameter int STARTUP_CYC = 10,
   parameter int RD_LAT      = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] ram_q,
   output logic [DW-1:0] ram_d,
   output logic [AW-1:0] ram_adr,
   output logic          ram_enb,
   output logic          ram_web,
   output logic          ram_oeb,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_cnt,
   output logic [AW-1:0] err_addr,
   output logic [DW-1:0] rd_data
);
   localparam int RD_CYC  = COUNT + RD_LAT;
   localparam int MAX_CYC = (STARTUP_CYC > RD_CYC) ? STARTUP_CYC : RD_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_STARTUP, S_WRITE, S_READ, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          accept;
   logic          issue_wr;
   logic          issue_rd;
   logic          last_issue;
   logic          pass_nxt;
   logic [AW-1:0] pat_adr;
   logic [DW-1:0] pat_dat;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      accept    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            cnt_nxt = '0;
            if (start && !busy) begin
               accept    = 1'b1;
               state_nxt = S_STARTUP;
            end
         end
         S_STARTUP: begin
            if (cnt == CW'(STARTUP_CYC - 1)) begin
               state_nxt = S_WRITE;
               cnt_nxt   = '0;
            end
         end
         S_WRITE: begin
            if (cnt == CW'(COUNT - 1)) begin
               cnt_nxt = '0;
`ifdef RAM_FILL_CHECKER_VERIFY_EN
               state_nxt = S_READ;
`else
               state_nxt = S_DONE;
`endif
            end
         end
         S_READ: begin
            if (cnt == CW'(RD_CYC - 1)) begin
               state_nxt = S_DONE;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign issue_wr   = (state == S_WRITE);
   assign last_issue = (cnt == CW'(COUNT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pat_adr <= '0;
         pat_dat <= '0;
         ram_enb <= 1'b1;
         ram_web <= 1'b1;
         ram_oeb <= 1'b1;
         ram_adr <= '0;
         ram_d   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ram_enb <= !(issue_wr || issue_rd);
         ram_web <= !issue_wr;
         ram_oeb <= !issue_rd;
         if (issue_wr || issue_rd)
            ram_adr <= pat_adr;
         if (issue_wr)
            ram_d <= pat_dat;
         // Pattern restarts at BASE/SEED after the last word of each pass
         if ((issue_wr || issue_rd) && !last_issue) begin
            pat_adr <= pat_adr + AW'(1);
            pat_dat <= pat_dat + DW'(STEP);
         end else begin
            pat_adr <= AW'(BASE);
            pat_dat <= DW'(SEED);
         end
         if (accept) begin
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
         end else if (state == S_DONE && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= pass_nxt;
         end
      end
   end

`ifdef RAM_FILL_CHECKER_VERIFY_EN
   logic [RD_LAT:0]         pipe_vld;
   logic [RD_LAT:0][DW-1:0] pipe_exp;
   logic [RD_LAT:0][AW-1:0] pipe_adr;
   logic                    sample;
   logic                    mismatch;
   logic [AW:0]             err_cnt_nxt;

   assign issue_rd = (state == S_READ) && (cnt < CW'(COUNT));
   assign sample   = pipe_vld[RD_LAT];
   assign mismatch = sample && (ram_q != pipe_exp[RD_LAT]);
   assign pass_nxt = (err_cnt_nxt == '0);

   always_comb begin
      err_cnt_nxt = err_cnt;
      if (mismatch && (err_cnt != '1))
         err_cnt_nxt = err_cnt + (AW+1)'(1);
   end

   // Expected word and address travel alongside the read so ram_q is compared RD_LAT cycles after capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_vld <= '0;
         pipe_exp <= '0;
         pipe_adr <= '0;
         err_cnt  <= '0;
         err_addr <= '0;
         rd_data  <= '0;
      end else begin
         pipe_vld <= {pipe_vld[RD_LAT-1:0], issue_rd};
         pipe_exp <= {pipe_exp[RD_LAT-1:0], pat_dat};
         pipe_adr <= {pipe_adr[RD_LAT-1:0], pat_adr};
         if (accept) begin
            err_cnt  <= '0;
            err_addr <= '0;
         end else begin
            err_cnt <= err_cnt_nxt;
            if (mismatch && (err_cnt == '0))
               err_addr <= pipe_adr[RD_LAT];
         end
         if (sample)
            rd_data <= ram_q;
      end
   end
`else
   logic unused_q;

   assign unused_q = ^ram_q;
   assign issue_rd = 1'b0;
   assign pass_nxt = 1'b1;
   assign err_cnt  = '0;
   assign err_addr = '0;
   assign rd_data  = '0;
`endif

endmodule

// File: tb/tb_ram_fill_checker.sv
// Bench for ram_fill_checker: two instances (default window, wrapping window with RD_LAT=2) against SRAM models with corruption masks.
`timescale 1ns/1ps
module tb_ram_fill_checker;
   localparam int A_BASE = 0,     A_COUNT = 10, A_SEED = 'hA0, A_STEP = 1, A_SC = 10, A_RL = 1;
   localparam int B_BASE = 'hFE,  B_COUNT = 4,  B_SEED = 'hFF, B_STEP = 2, B_SC = 10, B_RL = 2;
`ifdef RAM_FILL_CHECKER_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       a_start, b_start;
   logic [7:0] a_q, a_d, a_adr, a_ea, a_rd;
   logic [7:0] b_q, b_q1, b_d, b_adr, b_ea, b_rd;
   logic       a_enb, a_web, a_oeb, a_busy, a_done, a_pass;
   logic       b_enb, b_web, b_oeb, b_busy, b_done, b_pass;
   logic [8:0] a_ec, b_ec;
   logic [7:0] a_mem [256];
   logic [7:0] b_mem [256];
   bit [255:0] cm_a, cm_b;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   ram_fill_checker #(.AW(8), .DW(8), .BASE(A_BASE), .COUNT(A_COUNT), .SEED(A_SEED), .STEP(A_STEP),
                      .STARTUP_CYC(A_SC), .RD_LAT(A_RL)) u_a (
      .clk(clk), .reset(reset), .start(a_start), .ram_q(a_q), .ram_d(a_d), .ram_adr(a_adr),
      .ram_enb(a_enb), .ram_web(a_web), .ram_oeb(a_oeb), .busy(a_busy), .done(a_done), .pass(a_pass),
      .err_cnt(a_ec), .err_addr(a_ea), .rd_data(a_rd));

   ram_fill_checker #(.AW(8), .DW(8), .BASE(B_BASE), .COUNT(B_COUNT), .SEED(B_SEED), .STEP(B_STEP),
                      .STARTUP_CYC(B_SC), .RD_LAT(B_RL)) u_b (
      .clk(clk), .reset(reset), .start(b_start), .ram_q(b_q), .ram_d(b_d), .ram_adr(b_adr),
      .ram_enb(b_enb), .ram_web(b_web), .ram_oeb(b_oeb), .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_cnt(b_ec), .err_addr(b_ea), .rd_data(b_rd));

   // SRAM models; reads of masked addresses come back with bits flipped
   always @(posedge clk) begin
      if (!a_enb && !a_web) a_mem[a_adr] <= a_d;
      if (!a_enb && !a_oeb) a_q <= a_mem[a_adr] ^ (cm_a[a_adr] ? 8'h5A : 8'h00);
      if (!b_enb && !b_web) b_mem[b_adr] <= b_d;
      if (!b_enb && !b_oeb) b_q1 <= b_mem[b_adr] ^ (cm_b[b_adr] ? 8'h5A : 8'h00);
      b_q <= b_q1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input int base, input int count, input int seed, input int step,
                                 input int slat, input int rlat, input bit [255:0] cm,
                                 output int e_cnt, output int e_adr, output int e_last,
                                 output int e_lat, output int e_rd);
      e_cnt = 0; e_adr = 0; e_last = 0;
      for (int i = 0; i < count; i++) begin
         int a, d;
         a = (base + i) % 256;
         d = (seed + i * step) % 256;
         if (cm[a]) begin
            if (e_cnt == 0) e_adr = a;
            e_cnt++;
         end
         e_last = cm[a] ? (d ^ 'h5A) : d;
      end
      e_lat = slat + 2 * count + rlat + 1;
      e_rd  = count;
      if (!VERIFY) begin
         e_cnt = 0; e_adr = 0; e_last = 0; e_rd = 0;
         e_lat = slat + count + 1;
      end
   endfunction

   task automatic check_end(input string s, input int base, input int count, input int seed, input int step,
                            input int slat, input int rlat, input bit [255:0] cm,
                            input int lat, input int wc, input int rc,
                            input logic dn, input logic bz, input logic ps, input logic enb, input logic oeb,
                            input logic [8:0] ec, input logic [7:0] ea, input logic [7:0] rd);
      int e_cnt, e_adr, e_last, e_lat, e_rd;
      model(base, count, seed, step, slat, rlat, cm, e_cnt, e_adr, e_last, e_lat, e_rd);
      check_val({s, "_latency"}, lat, e_lat);
      check_val({s, "_done"}, dn, 1);
      check_val({s, "_busy"}, bz, 0);
      check_val({s, "_pass"}, ps, (e_cnt == 0));
      check_val({s, "_err_cnt"}, ec, e_cnt);
      check_val({s, "_err_addr"}, ea, e_adr);
      check_val({s, "_rd_data"}, rd, e_last);
      check_val({s, "_writes"}, wc, count);
      check_val({s, "_reads"}, rc, e_rd);
      check_val({s, "_enb_idle"}, enb, 1);
      check_val({s, "_oeb_idle"}, oeb, 1);
   endtask

   // Called on a negedge; hold keeps start high until that instance reports done
   task automatic do_run(input bit hold);
      int wa = 0, wb = 0, ra = 0, rb = 0, la = -1, lb = -1, n = 0;
      a_start = 1'b1;
      b_start = 1'b1;
      @(posedge clk); #1;
      check_val("a_accept_busy", a_busy, 1);
      check_val("a_accept_done", a_done, 0);
      check_val("b_accept_busy", b_busy, 1);
      check_val("b_accept_done", b_done, 0);
      if (!hold) begin
         a_start = 1'b0;
         b_start = 1'b0;
      end
      while ((la < 0 || lb < 0) && n < 400) begin
         @(negedge clk);
         if (!a_enb && !a_web) begin
            check_val("a_wr_adr", a_adr, (A_BASE + wa) % 256);
            check_val("a_wr_dat", a_d, (A_SEED + wa * A_STEP) % 256);
            wa++;
         end
         if (!a_oeb) begin
            check_val("a_rd_adr", a_adr, (A_BASE + ra) % 256);
            check_val("a_rd_enb", a_enb, 0);
            ra++;
         end
         if (!b_enb && !b_web) begin
            check_val("b_wr_adr", b_adr, (B_BASE + wb) % 256);
            check_val("b_wr_dat", b_d, (B_SEED + wb * B_STEP) % 256);
            wb++;
         end
         if (!b_oeb) begin
            check_val("b_rd_adr", b_adr, (B_BASE + rb) % 256);
            check_val("b_rd_enb", b_enb, 0);
            rb++;
         end
         if (la < 0 && a_done) la = n;
         if (lb < 0 && b_done) lb = n;
         n++;
         a_start = (la < 0) && (hold || $urandom_range(0, 5) == 0);
         b_start = (lb < 0) && (hold || $urandom_range(0, 5) == 0);
      end
      a_start = 1'b0;
      b_start = 1'b0;
      check_end("a", A_BASE, A_COUNT, A_SEED, A_STEP, A_SC, A_RL, cm_a, la, wa, ra,
                a_done, a_busy, a_pass, a_enb, a_oeb, a_ec, a_ea, a_rd);
      check_end("b", B_BASE, B_COUNT, B_SEED, B_STEP, B_SC, B_RL, cm_b, lb, wb, rb,
                b_done, b_busy, b_pass, b_enb, b_oeb, b_ec, b_ea, b_rd);
   endtask

   initial begin
      reset   = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      cm_a    = '0;
      cm_b    = '0;
      #12;
      check_val("rst_enb", a_enb, 1);
      check_val("rst_web", a_web, 1);
      check_val("rst_oeb", a_oeb, 1);
      check_val("rst_adr", a_adr, 0);
      check_val("rst_d", a_d, 0);
      check_val("rst_busy", a_busy, 0);
      check_val("rst_done", a_done, 0);
      check_val("rst_pass", a_pass, 0);
      check_val("rst_err_cnt", a_ec, 0);
      check_val("rst_err_addr", a_ea, 0);
      check_val("rst_rd_data", a_rd, 0);
      check_val("rst_b_enb", b_enb, 1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      do_run(1'b0);

      cm_a[5] = 1'b1;
      cm_a[7] = 1'b1;
      cm_b['hFF] = 1'b1;
      do_run(1'b0);

      cm_a = '0;
      cm_b = '0;
      begin : mid_reset
         int nw, n;
         nw = 0;
         n  = 0;
         a_start = 1'b1;
         b_start = 1'b1;
         @(posedge clk); #1;
         a_start = 1'b0;
         b_start = 1'b0;
         while (nw < 4 && n < 100) begin
            @(negedge clk);
            if (!a_enb && !a_web) nw++;
            n++;
         end
         check_val("rst_mid_reach_wr4", nw, 4);
         #2 reset = 1'b1;
         #1;
         check_val("rst_mid_web", a_web, 1);
         check_val("rst_mid_enb", a_enb, 1);
         check_val("rst_mid_busy", a_busy, 0);
         check_val("rst_mid_adr", a_adr, 0);
         check_val("rst_mid_b_enb", b_enb, 1);
         check_val("rst_mid_b_busy", b_busy, 0);
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
      end
      do_run(1'b0);

      do_run(1'b1);
      do_run(1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 8; k++) begin
            cm_a[k*32 +: 32] = $urandom & $urandom & $urandom;
            cm_b[k*32 +: 32] = $urandom & $urandom;
         end
         repeat ($urandom_range(0, 4)) @(negedge clk);
         do_run(1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
